// File: rtl/pipeline_skid_reg.sv
// Two-entry registered skid buffer between valid/ready pipeline stages; all handshake outputs come straight from flops.
// Optional synchronous flush port and logic are built only when macro PIPE_FLUSH_EN is defined.
module pipeline_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] TWO   = 2'b10;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] main_next_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_next_s;
    logic             in_fire_s;
    logic             out_fire_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Next-state and next-entry selection; in TWO in_ready_r is low so in_data is never sampled.
    always_comb begin
        state_next_s = state_r;
        main_next_s  = main_r;
        skid_next_s  = skid_r;
        case (state_r)
            EMPTY: begin
                if (in_fire_s) begin
                    state_next_s = ONE;
                    main_next_s  = in_data;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ONE: begin
                if (in_fire_s && out_fire_s) begin
                    state_next_s = ONE;
                    main_next_s  = in_data;
                end else if (in_fire_s) begin
                    state_next_s = TWO;
                    skid_next_s  = in_data;
                end else if (out_fire_s) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = ONE;
                end
            end
            TWO: begin
                if (out_fire_s) begin
                    state_next_s = ONE;
                    main_next_s  = skid_r;
                end else begin
                    state_next_s = TWO;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
`ifdef PIPE_FLUSH_EN
        // Flush wins over both handshakes and leaves the data registers untouched.
        if (flush) begin
            state_next_s = EMPTY;
            main_next_s  = main_r;
            skid_next_s  = skid_r;
        end else begin
            state_next_s = state_next_s;
        end
`endif
    end

    // State, handshake flags and entry storage; flags are decoded from the next state so outputs stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            main_r      <= '0;
            skid_r      <= '0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != TWO);
            out_valid_r <= (state_next_s != EMPTY);
            main_r      <= main_next_s;
            skid_r      <= skid_next_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;

    pipeline_skid_reg_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .state     (state_r),
        .in_ready  (in_ready_r),
        .out_valid (out_valid_r)
    );

endmodule

// Consistency checks between the state encoding and the registered handshake flags.
module pipeline_skid_reg_chk (
    input logic       clk,
    input logic       rst,
    input logic [1:0] state,
    input logic       in_ready,
    input logic       out_valid
);

    a_state_legal: assert property (@(posedge clk) disable iff (rst) (state != 2'b11));
    a_ready_match: assert property (@(posedge clk) disable iff (rst) (in_ready == (state != 2'b10)));
    a_valid_match: assert property (@(posedge clk) disable iff (rst) (out_valid == (state != 2'b00)));

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Directed and scoreboard bench for pipeline_skid_reg; flush scenario built when PIPE_FLUSH_EN is defined.
module tb_pipeline_skid_reg;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_FLUSH_EN
    logic         flush;
`endif

    int checks;
    int passes;

    pipeline_skid_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 32'h0;
        out_ready = 1'b0;
`ifdef PIPE_FLUSH_EN
        flush = 1'b0;
`endif
        cyc();
        cyc();
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h expected 0", out_data); else passes++;
        rst = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) $display("FAIL post_reset_idle: got %b expected 0", out_valid); else passes++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h11;
        checks++; if (out_valid !== 1'b0) $display("FAIL empty_same_cycle: got %b expected 0", out_valid); else passes++;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h11) $display("FAIL stream_11: got v=%b d=%h expected v=1 d=11", out_valid, out_data); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL stream_ready1: got %b expected 1", in_ready); else passes++;
        in_data = 32'h22;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h22) $display("FAIL stream_22: got v=%b d=%h expected v=1 d=22", out_valid, out_data); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL stream_ready2: got %b expected 1", in_ready); else passes++;
        in_data = 32'h33;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h33) $display("FAIL stream_33: got v=%b d=%h expected v=1 d=33", out_valid, out_data); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL stream_ready3: got %b expected 1", in_ready); else passes++;
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stream_drain: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); else passes++;
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b1) $display("FAIL skid_one: got v=%b d=%h r=%b expected v=1 d=a r=1", out_valid, out_data, in_ready); else passes++;
        in_data = 32'hB;
        cyc();
        checks++; if (in_ready !== 1'b0 || out_data !== 32'hA || out_valid !== 1'b1) $display("FAIL skid_two: got v=%b d=%h r=%b expected v=1 d=a r=0", out_valid, out_data, in_ready); else passes++;
        in_data = 32'hC;
        cyc();
        checks++; if (in_ready !== 1'b0 || out_data !== 32'hA) $display("FAIL skid_hold: got d=%h r=%b expected d=a r=0", out_data, in_ready); else passes++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) $display("FAIL skid_pop1: got v=%b d=%h r=%b expected v=1 d=b r=1", out_valid, out_data, in_ready); else passes++;
        cyc();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'hB) $display("FAIL skid_pop2: got v=%b d=%h expected v=0 d=b", out_valid, out_data); else passes++;
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] prev_data;
        logic         prev_stall;
        logic         exp_ready;
        logic         exp_valid;
        logic         fi;
        logic         fo;
        logic [W-1:0] next_val;
        int           errs;
        errs = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        next_val = 32'h1000;
        for (int c = 0; c < 1004; c++) begin
            exp_ready = (q.size() < 2);
            exp_valid = (q.size() > 0);
            checks++;
            if (in_ready !== exp_ready || out_valid !== exp_valid || (exp_valid && out_data !== q[0])) begin
                $display("FAIL rand_cycle%0d: got r=%b v=%b d=%h expected r=%b v=%b d=%h", c, in_ready, out_valid, out_data, exp_ready, exp_valid, exp_valid ? q[0] : 32'h0);
                errs++;
            end else passes++;
            if (prev_stall) begin
                checks++;
                if (out_data !== prev_data) $display("FAIL rand_stable%0d: got %h expected %h", c, out_data, prev_data); else passes++;
            end
            if (c < 1000) begin
                in_valid = ($urandom_range(1, 0) == 1);
                out_ready = ($urandom_range(1, 0) == 1);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            in_data = next_val;
            fi = in_valid && exp_ready;
            fo = exp_valid && out_ready;
            prev_stall = exp_valid && !out_ready;
            prev_data = out_data;
            cyc();
            if (fo) void'(q.pop_front());
            if (fi) begin
                q.push_back(next_val);
                next_val = next_val + 32'h1;
            end
        end
        checks++; if (q.size() != 0 || out_valid !== 1'b0) $display("FAIL rand_drained: got v=%b pending=%0d expected v=0 pending=0", out_valid, q.size()); else passes++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h77;
        cyc();
        in_data = 32'h88;
        cyc();
        checks++; if (in_ready !== 1'b0) $display("FAIL areset_pre_two: got %b expected 0", in_ready); else passes++;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) $display("FAIL areset_immediate: got v=%b r=%b d=%h expected v=0 r=1 d=0", out_valid, in_ready, out_data); else passes++;
        #1;
        rst = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) $display("FAIL areset_empty: got %b expected 0", out_valid); else passes++;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = 32'h99;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h99) $display("FAIL areset_first: got v=%b d=%h expected v=1 d=99", out_valid, out_data); else passes++;
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) $display("FAIL areset_no_stale: got %b expected 0", out_valid); else passes++;
    endtask

`ifdef PIPE_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h41;
        cyc();
        in_data = 32'h42;
        cyc();
        in_data = 32'h55;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h41) $display("FAIL flush_empty: got v=%b r=%b d=%h expected v=0 r=1 d=41", out_valid, in_ready, out_data); else passes++;
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0 || out_data === 32'h55) $display("FAIL flush_dropped: got v=%b d=%h expected v=0 d!=55", out_valid, out_data); else passes++;
        in_valid = 1'b1;
        in_data = 32'h66;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h66) $display("FAIL flush_resume: got v=%b d=%h expected v=1 d=66", out_valid, out_data); else passes++;
        cyc();
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_stream();
        test_skid();
        test_random();
        test_async_reset();
`ifdef PIPE_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
